// File: rtl/score_digit_scanner.sv
// Binary score to four BCD digits (sequential double-dabble) with a multiplexed 4-digit display scan.
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits; the units digit always stays lit.
module score_digit_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int SCORE_W     = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  output logic               busy,
  output logic [3:0]         displayed_digit,
  output logic [3:0]         anode
);

  localparam int SR_W  = 16 + SCORE_W;
  localparam int CNT_W = $clog2(SCORE_W);
  localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(SCORE_W - 1);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t             state;
  state_t             state_next;
  logic [SR_W-1:0]    shift_reg;
  logic [SCORE_W-1:0] shadow;
  logic [SCORE_W-1:0] load_value;
  logic               pending;
  logic [CNT_W-1:0]   step;
  logic [15:0]        bcd;
  logic [REF_W-1:0]   refresh_cnt;
  logic [1:0]         index;
  logic               lit;

  function automatic logic [SCORE_W-1:0] saturate(input logic [SCORE_W-1:0] value);
    logic [13:0] wide;
    wide = 14'(value);
    if (wide > 14'd9999) wide = 14'd9999;
    return wide[SCORE_W-1:0];
  endfunction

  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] adj;
    logic [3:0]      nib;
    adj = sr;
    for (int d = 0; d < 4; d++) begin
      nib = adj[SCORE_W + 4*d +: 4];
      if (nib >= 4'd5) adj[SCORE_W + 4*d +: 4] = nib + 4'd3;
    end
    return {adj[SR_W-2:0], 1'b0};
  endfunction

  // A strobe arriving in the same cycle as COMMIT is newer than anything in the shadow.
  assign load_value = score_valid ? saturate(score) : shadow;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (score_valid) state_next = CONV;
      CONV:    if (step == LAST_STEP) state_next = COMMIT;
      COMMIT:  state_next = (pending || score_valid) ? CONV : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      shadow    <= '0;
      pending   <= 1'b0;
      step      <= '0;
      bcd       <= '0;
    end else begin
      if (score_valid) shadow <= saturate(score);
      case (state)
        IDLE: begin
          if (score_valid) begin
            shift_reg <= {16'd0, saturate(score)};
            step      <= '0;
          end
        end
        CONV: begin
          shift_reg <= dabble_step(shift_reg);
          step      <= step + 1'b1;
          if (score_valid) pending <= 1'b1;
        end
        COMMIT: begin
          bcd     <= shift_reg[SR_W-1 -: 16];
          pending <= 1'b0;
          if (pending || score_valid) begin
            shift_reg <= {16'd0, load_value};
            step      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    lit = 1'b1;
    case (index)
      2'd3:    lit = (bcd[15:12] != 4'd0);
      2'd2:    lit = (bcd[15:8]  != 8'd0);
      2'd1:    lit = (bcd[15:4]  != 12'd0);
      default: lit = 1'b1;
    endcase
  end
`else
  assign lit = 1'b1;
`endif

  // Scan timing free-runs; outputs are registered one cycle behind the digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt     <= '0;
      index           <= 2'd0;
      anode           <= 4'b1111;
      displayed_digit <= 4'd0;
    end else begin
      if (refresh_cnt == REF_LAST) begin
        refresh_cnt <= '0;
        index       <= index + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      anode           <= lit ? ~(4'b0001 << index) : 4'b1111;
      displayed_digit <= bcd[{index, 2'b00} +: 4];
    end
  end

endmodule

// File: doc/score_digit_scanner.md
Name: score_digit_scanner

Overview:
- Upstream feeder of the seven-segment cathode decoder in the score display path.
- Accepts a binary game score and converts it to four BCD digits with a sequential double-dabble engine.
- Time-multiplexes the four digits onto the shared displayed_digit bus while driving the matching active-low anode.
- The cathode decoder consumes displayed_digit combinationally; this block owns all display timing.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays lit (100 MHz gives 1 kHz per digit); legal range 2..2^20.
- SCORE_W, 14, width of the binary score input; legal range 4..14.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- score  input  SCORE_W  binary score, sampled only when score_valid=1.
- score_valid  input  1  single-cycle strobe; request conversion of score.
- busy  output  1  high while a conversion is in progress.
- displayed_digit  output  4  BCD digit for the currently lit position; goes to the cathode decoder.
- anode  output  4  active-low digit enables; bit0 = units, bit3 = thousands.

Behaviour:
- Reset values (asynchronous, reset=1):
  - anode=4'b1111, displayed_digit=0, busy=0.
  - BCD digit registers=0, pending flag=0, refresh counter=0, digit index=0, FSM=IDLE.
- Input capture and saturation:
  - On score_valid, score is captured into a shadow register.
  - Values >9999 saturate to 9999 at capture.
- FSM IDLE:
  - On score_valid, capture the input, load the shift register, set busy=1, go to CONV.
- FSM CONV:
  - One double-dabble step per cycle, SCORE_W steps.
  - Each step adds 3 to every BCD nibble that is >=5, then shifts left by 1.
  - After the last step, go to COMMIT.
- FSM COMMIT:
  - Copy the 16-bit BCD result into the displayed-digit registers in one cycle.
  - If pending=1, reload from the shadow register, clear pending, go to CONV with busy held at 1.
  - Otherwise set busy=0 and go to IDLE.
- Latency:
  - score_valid at cycle N gives new BCD registers visible at cycle N+SCORE_W+2.
  - busy rises at N+1 and falls at N+SCORE_W+2.
- score_valid while busy:
  - The shadow register is overwritten (last value wins) and pending is set.
  - The conversion in progress is never aborted.
  - Intermediate values are never displayed half-converted; BCD registers change only in COMMIT.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, the digit index advances 0->1->2->3->0.
- Outputs (registered, updated together on the cycle after an index change):
  - anode = ~(4'b0001 << index).
  - displayed_digit = BCD[index].
  - First cycle after reset release: anode=4'b1110, displayed_digit=units digit (0).
- Digit values: every nibble presented on displayed_digit is 0..9. Values 10..15 are never driven.
- Reset asserted mid-conversion: everything returns to reset values immediately, the pending request is discarded, and the display shows 0000.

Optional Feature:
- LEADING_ZERO_BLANK_EN
- Defined:
  - While a position is selected that is more significant than the highest non-zero digit, anode stays 4'b1111 for that slot; scan timing is unchanged.
  - The units digit is always lit, so a score of 0 shows a single "0".
  - displayed_digit still carries 0 in blanked slots.
- Undefined: all four digits are always lit, with leading zeros shown.

Test Plan:
- Reset, then release with REFRESH_DIV=4 -> anode sequence 1110,1101,1011,0111 each held 4 cycles, repeating; displayed_digit=0 throughout; busy=0.
- score=1234 with score_valid pulse at cycle N, SCORE_W=14 -> busy high cycles N+1..N+15; from N+16 the units slot shows 4, tens 3, hundreds 2, thousands 1.
- score=16383 -> saturates; all four slots show 9.
- score=100 strobed, then score=7 strobed 3 cycles later and score=58 strobed 5 cycles later -> display shows 0100, then 0058 after a second back-to-back conversion; 7 is never displayed; busy stays high continuously between the two conversions.
- reset pulsed 5 cycles into conversion of 4321 -> outputs return to reset values at once; display remains 0000 after release with no score_valid.
- With LEADING_ZERO_BLANK_EN defined, score=42 -> thousands and hundreds slots show anode=1111, tens slot shows 1101 with digit 4, units slot shows 1110 with digit 2; score=0 -> only the units slot is lit.
